// File: rtl/mux_bus_responder.sv
// Multiplexed address/data bus responder: 16x8 register file at upper nibble BASE_NIBBLE.
// Optional macro MUXBUS_AUTOINC_EN: completed accesses step addr[3:0] and park in ADDR.
module mux_bus_responder #(
  parameter logic [3:0]  BASE_NIBBLE = 4'h0,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ale,
  input  logic       en,
  input  logic       rw,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       rdy,
  input  logic [3:0] dbg_sel,
  output logic [7:0] dbg_out
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_WAIT = 3'd2,
    S_DATA = 3'd3,
    S_SKIP = 3'd4
  } state_t;

  localparam logic [2:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 3'd0 : 3'(WAIT_CYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] addr_q, addr_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] ad_out_q, ad_out_d;
  logic       ad_oe_q, ad_oe_d;
  logic       rdy_q, rdy_d;
  logic       first_q, first_d;
  logic       wr_en;
  logic       hit;
  logic [7:0] mem_q [16];

  assign hit = (addr_q[7:4] == BASE_NIBBLE);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ale) begin
          addr_d  = ad_in;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (ale) begin
          addr_d = ad_in;
        end else if (en) begin
          if (!hit) begin
            state_d = S_SKIP;
          end else if (WAIT_CYCLES == 0) begin
            state_d = S_DATA;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (ale) begin
          addr_d  = ad_in;
          state_d = S_ADDR;
        end else if (!en) begin
          state_d = S_IDLE;
        end else if (cnt_q == 3'd0) begin
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_DATA: begin
        if (ale) begin
          addr_d  = ad_in;
          state_d = S_ADDR;
        end else begin
          // Only the first data cycle commits a write; later rw flips are ignored.
          wr_en = first_q && !rw;
          if (!en) begin
`ifdef MUXBUS_AUTOINC_EN
            addr_d  = {addr_q[7:4], addr_q[3:0] + 4'd1};
            state_d = S_ADDR;
`else
            state_d = S_IDLE;
`endif
          end
        end
      end
      S_SKIP: begin
        if (ale) begin
          addr_d  = ad_in;
          state_d = S_ADDR;
        end else if (!en) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered off the next state so they move on the same edge as the FSM.
  always_comb begin
    first_d  = (state_d == S_DATA) && (state_q != S_DATA);
    rdy_d    = (state_d == S_DATA);
    ad_oe_d  = (state_d == S_DATA) && rw;
    ad_out_d = (first_d && rw) ? mem_q[addr_q[3:0]] : ad_out_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      addr_q   <= 8'h00;
      cnt_q    <= 3'd0;
      ad_out_q <= 8'h00;
      ad_oe_q  <= 1'b0;
      rdy_q    <= 1'b0;
      first_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      ad_out_q <= ad_out_d;
      ad_oe_q  <= ad_oe_d;
      rdy_q    <= rdy_d;
      first_q  <= first_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (wr_en) begin
      mem_q[addr_q[3:0]] <= ad_in;
    end
  end

  assign ad_out  = ad_out_q;
  assign ad_oe   = ad_oe_q;
  assign rdy     = rdy_q;
  assign dbg_out = mem_q[dbg_sel];

endmodule

// File: tb/tb_mux_bus_responder.sv
// Directed bench: one-wait-state instance driven from a vector table, plus
// three-wait and zero-wait instances exercised by hand-written sequences.
module tb_mux_bus_responder;

  logic       clk;
  logic       rst_n;
  logic       ale, en, rw;
  logic [7:0] ad_in;
  logic [3:0] dbg_sel;

  logic [7:0] out1, out3, outz;
  logic       oe1, oe3, oez;
  logic       rdy1, rdy3, rdyz;
  logic [7:0] dbg1, dbg3, dbgz;

  int nvec = 0;
  int nerr = 0;

  mux_bus_responder #(.BASE_NIBBLE(4'h0), .WAIT_CYCLES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .ale(ale), .en(en), .rw(rw), .ad_in(ad_in),
    .ad_out(out1), .ad_oe(oe1), .rdy(rdy1), .dbg_sel(dbg_sel), .dbg_out(dbg1));

  mux_bus_responder #(.BASE_NIBBLE(4'h0), .WAIT_CYCLES(3)) u3 (
    .clk(clk), .rst_n(rst_n), .ale(ale), .en(en), .rw(rw), .ad_in(ad_in),
    .ad_out(out3), .ad_oe(oe3), .rdy(rdy3), .dbg_sel(dbg_sel), .dbg_out(dbg3));

  mux_bus_responder #(.BASE_NIBBLE(4'h0), .WAIT_CYCLES(0)) uz (
    .clk(clk), .rst_n(rst_n), .ale(ale), .en(en), .rw(rw), .ad_in(ad_in),
    .ad_out(outz), .ad_oe(oez), .rdy(rdyz), .dbg_sel(dbg_sel), .dbg_out(dbgz));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ale;
    logic       en;
    logic       rw;
    logic [7:0] ad;
    logic [3:0] sel;
    logic       rdy;
    logic       oe;
    logic [7:0] out;
    logic [7:0] dbg;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic a, input logic e, input logic r, input logic [7:0] d,
                     input logic [3:0] s, input logic xr, input logic xo,
                     input logic [7:0] xout, input logic [7:0] xdbg);
    vec_t v;
    v.ale = a; v.en = e; v.rw = r; v.ad = d; v.sel = s;
    v.rdy = xr; v.oe = xo; v.out = xout; v.dbg = xdbg;
    tbl.push_back(v);
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic a, input logic e, input logic r, input logic [7:0] d);
    ale = a; en = e; rw = r; ad_in = d;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  logic [7:0] exp_m0, exp_m1;

  initial begin
    rst_n   = 1'b1;
    dbg_sel = 4'h0;
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    #2;
    do_reset();

    // Reset state
    dbg_sel = 4'hF;
    #1;
    chk1("reset_rdy", rdy1, 1'b0);
    chk1("reset_oe", oe1, 1'b0);
    chk8("reset_out", out1, 8'h00);
    chk8("reset_mem15", dbg1, 8'h00);

    //   ale  en   rw   ad     sel   rdy  oe   out    dbg
    add(1'b0,1'b1,1'b0,8'h5A,4'h0,1'b0,1'b0,8'h00,8'h00); // en in IDLE ignored
    add(1'b0,1'b1,1'b0,8'h5A,4'h0,1'b0,1'b0,8'h00,8'h00);
    add(1'b1,1'b0,1'b0,8'h05,4'h5,1'b0,1'b0,8'h00,8'h00); // latch 05
    add(1'b0,1'b1,1'b0,8'hA5,4'h5,1'b0,1'b0,8'h00,8'h00); // WAIT
    add(1'b0,1'b1,1'b0,8'hA5,4'h5,1'b1,1'b0,8'h00,8'h00); // DATA entry
    add(1'b0,1'b1,1'b0,8'hA5,4'h5,1'b1,1'b0,8'h00,8'hA5); // first DATA cycle writes
    add(1'b0,1'b0,1'b0,8'h00,4'h5,1'b0,1'b0,8'h00,8'hA5); // complete
    add(1'b1,1'b0,1'b0,8'h05,4'h5,1'b0,1'b0,8'h00,8'hA5); // read 05
    add(1'b0,1'b1,1'b1,8'h00,4'h5,1'b0,1'b0,8'h00,8'hA5);
    add(1'b0,1'b1,1'b1,8'h00,4'h5,1'b1,1'b1,8'hA5,8'hA5);
    add(1'b0,1'b1,1'b1,8'h00,4'h5,1'b1,1'b1,8'hA5,8'hA5);
    add(1'b0,1'b1,1'b0,8'hFF,4'h5,1'b1,1'b0,8'hA5,8'hA5); // rw flip: no write
    add(1'b0,1'b0,1'b0,8'h00,4'h5,1'b0,1'b0,8'hA5,8'hA5);
    add(1'b1,1'b0,1'b0,8'h35,4'h5,1'b0,1'b0,8'hA5,8'hA5); // miss
    add(1'b0,1'b1,1'b0,8'hFF,4'h5,1'b0,1'b0,8'hA5,8'hA5);
    add(1'b0,1'b1,1'b1,8'hFF,4'h5,1'b0,1'b0,8'hA5,8'hA5);
    add(1'b0,1'b0,1'b0,8'h00,4'h5,1'b0,1'b0,8'hA5,8'hA5);
    add(1'b1,1'b0,1'b0,8'h07,4'h7,1'b0,1'b0,8'hA5,8'h00); // ale aborts in DATA
    add(1'b0,1'b1,1'b0,8'h3C,4'h7,1'b0,1'b0,8'hA5,8'h00);
    add(1'b0,1'b1,1'b0,8'h3C,4'h7,1'b1,1'b0,8'hA5,8'h00);
    add(1'b1,1'b1,1'b0,8'h07,4'h7,1'b0,1'b0,8'hA5,8'h00);
    add(1'b0,1'b0,1'b0,8'h3C,4'h7,1'b0,1'b0,8'hA5,8'h00);
    add(1'b1,1'b0,1'b0,8'h09,4'h9,1'b0,1'b0,8'hA5,8'h00); // re-latch in ADDR
    add(1'b0,1'b1,1'b0,8'h4D,4'h9,1'b0,1'b0,8'hA5,8'h00);
    add(1'b0,1'b1,1'b0,8'h4D,4'h9,1'b1,1'b0,8'hA5,8'h00);
    add(1'b0,1'b0,1'b0,8'h4D,4'h9,1'b0,1'b0,8'hA5,8'h4D); // en drops in first cycle
    add(1'b0,1'b0,1'b0,8'h00,4'h7,1'b0,1'b0,8'hA5,8'h00);

    foreach (tbl[i]) begin
      drive(tbl[i].ale, tbl[i].en, tbl[i].rw, tbl[i].ad);
      dbg_sel = tbl[i].sel;
      step();
      chk1($sformatf("v%0d_rdy", i), rdy1, tbl[i].rdy);
      chk1($sformatf("v%0d_oe", i), oe1, tbl[i].oe);
      chk8($sformatf("v%0d_out", i), out1, tbl[i].out);
      chk8($sformatf("v%0d_dbg", i), dbg1, tbl[i].dbg);
    end

    // Reset in the middle of a read data phase
    drive(1'b1, 1'b0, 1'b0, 8'h05);
    dbg_sel = 4'h5;
    step();
    drive(1'b0, 1'b1, 1'b1, 8'h00);
    step();
    step();
    chk1("rst_pre_rdy", rdy1, 1'b1);
    chk1("rst_pre_oe", oe1, 1'b1);
    chk8("rst_pre_out", out1, 8'hA5);
    #2;
    rst_n = 1'b0;
    #1;
    chk1("rst_async_rdy", rdy1, 1'b0);
    chk1("rst_async_oe", oe1, 1'b0);
    chk8("rst_async_out", out1, 8'h00);
    chk8("rst_async_mem5", dbg1, 8'h00);
    do_reset();

    // Zero wait states: write then read addr 3
    drive(1'b1, 1'b0, 1'b0, 8'h03);
    dbg_sel = 4'h3;
    step();
    chk1("w0_addr_rdy", rdyz, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 8'h5A);
    step();
    chk1("w0_wr_rdy", rdyz, 1'b1);
    chk1("w0_wr_oe", oez, 1'b0);
    step();
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    step();
    chk8("w0_mem3", dbgz, 8'h5A);
    drive(1'b1, 1'b0, 1'b0, 8'h03);
    step();
    drive(1'b0, 1'b1, 1'b1, 8'h00);
    step();
    chk1("w0_rd_rdy", rdyz, 1'b1);
    chk1("w0_rd_oe", oez, 1'b1);
    chk8("w0_rd_out", outz, 8'h5A);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    step();

    // Three wait states: en dropped during WAIT, then full read timing
    do_reset();
    dbg_sel = 4'h2;
    drive(1'b1, 1'b0, 1'b0, 8'h02);
    step();
    drive(1'b0, 1'b1, 1'b0, 8'h77);
    step();
    step();
    chk1("w3_wait_rdy", rdy3, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 8'h77);
    step();
    chk1("w3_abort_rdy", rdy3, 1'b0);
    chk8("w3_abort_mem2", dbg3, 8'h00);
    drive(1'b0, 1'b1, 1'b0, 8'h77);
    for (int k = 0; k < 5; k++) begin
      step();
      chk1($sformatf("w3_idle%0d_rdy", k), rdy3, 1'b0);
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    step();
    chk8("w3_idle_mem2", dbg3, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 8'h02);
    step();
    drive(1'b0, 1'b1, 1'b1, 8'h00);
    step();
    step();
    step();
    chk1("w3_cnt_rdy", rdy3, 1'b0);
    step();
    chk1("w3_data_rdy", rdy3, 1'b1);
    chk1("w3_data_oe", oe3, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    step();
    chk1("w3_done_oe", oe3, 1'b0);

    // Back-to-back write pulses without ale
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 8'h0F);
    step();
    for (int p = 0; p < 3; p++) begin
      drive(1'b0, 1'b1, 1'b0, 8'(8'h11 * (p + 1)));
      step();
      step();
      step();
      drive(1'b0, 1'b0, 1'b0, 8'h00);
      step();
    end
`ifdef MUXBUS_AUTOINC_EN
    exp_m0 = 8'h22;
    exp_m1 = 8'h33;
`else
    exp_m0 = 8'h00;
    exp_m1 = 8'h00;
`endif
    dbg_sel = 4'hF;
    #1;
    chk8("inc_mem15", dbg1, 8'h11);
    dbg_sel = 4'h0;
    #1;
    chk8("inc_mem0", dbg1, exp_m0);
    dbg_sel = 4'h1;
    #1;
    chk8("inc_mem1", dbg1, exp_m1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
